// File: rtl/map_table_if.sv
// Shared packed structs and the dispatch/CDB/AMT bundle of the rename map table.
// Widths follow the default 32 architectural / 64 physical register configuration.
package map_table_pkg;
  localparam int unsigned MT_AR_W  = 5;
  localparam int unsigned MT_TAG_W = 6;
  localparam int unsigned MT_ROB_W = 5;
  localparam int unsigned MT_THR_W = 1;

  typedef struct packed {
    logic                valid;
    logic [MT_TAG_W-1:0] tag;
    logic [MT_ROB_W-1:0] rob_idx;
    logic [MT_THR_W-1:0] thread_idx;
    logic                br_result;
  } CDB;

  typedef struct packed {
    logic [MT_AR_W-1:0]  rs1;
    logic [MT_AR_W-1:0]  rs2;
    logic                read_en;
    logic [MT_THR_W-1:0] thread_idx;
  } DP_MT_READ;

  typedef struct packed {
    logic [MT_AR_W-1:0]  rd;
    logic [MT_TAG_W-1:0] tag;
    logic                write_en;
    logic [MT_THR_W-1:0] thread_idx;
  } DP_MT_WRITE;

  typedef struct packed {
    logic [MT_TAG_W-1:0] amt_tag;
  } AMT_ENTRY;

  typedef struct packed {
    logic [MT_TAG_W-1:0] tag1;
    logic                tag1_ready;
    logic [MT_TAG_W-1:0] tag2;
    logic                tag2_ready;
    logic [MT_TAG_W-1:0] tag_old;
  } MT_DP;
endpackage

interface map_table_if #(
  parameter int unsigned DP_NUM   = 2,
  parameter int unsigned MT_ENTRY = 32,
  parameter int unsigned CDB_NUM  = 2
);
  import map_table_pkg::*;

  logic                           rollback_i;
  CDB         [CDB_NUM-1:0]       cdb_i;
  DP_MT_READ  [DP_NUM-1:0]        dp_mt_read_i;
  DP_MT_WRITE [DP_NUM-1:0]        dp_mt_write_i;
  AMT_ENTRY   [MT_ENTRY-1:0]      amt_i;
  MT_DP       [DP_NUM-1:0]        mt_dp_o;

  modport master (
    output rollback_i, cdb_i, dp_mt_read_i, dp_mt_write_i, amt_i,
    input  mt_dp_o
  );

  modport slave (
    input  rollback_i, cdb_i, dp_mt_read_i, dp_mt_write_i, amt_i,
    output mt_dp_o
  );
endinterface

// File: rtl/map_table.sv
// Register-rename map table: combinational lookups with intra-group forwarding, edge writes.
// Define MT_CDB_BYPASS_EN to let same-cycle CDB broadcasts mark table-sourced reads ready.
module map_table
  import map_table_pkg::*;
#(
  parameter int unsigned DP_NUM    = 2,
  parameter int unsigned MT_ENTRY  = 32,
  parameter int unsigned CDB_NUM   = 2,
  parameter int unsigned PRF_ENTRY = 64
) (
  input  logic        clk_i,
  input  logic        rst_i,
  map_table_if.slave  mt
);
  localparam int unsigned AR_W  = $clog2(MT_ENTRY);
  localparam int unsigned TAG_W = $clog2(PRF_ENTRY);

  logic [MT_ENTRY-1:0][TAG_W-1:0] tag_q;
  logic [MT_ENTRY-1:0]            ready_q;
  logic [MT_ENTRY-1:0]            eff_ready;
  logic                           unused_ok;

  // Bypass is applied to stored entries only, so forwarded tags stay not-ready.
  always_comb begin
    eff_ready = ready_q;
`ifdef MT_CDB_BYPASS_EN
    for (int unsigned k = 0; k < MT_ENTRY; k++)
      for (int unsigned c = 0; c < CDB_NUM; c++)
        if (mt.cdb_i[c].valid && mt.cdb_i[c].tag == tag_q[k])
          eff_ready[k] = 1'b1;
`endif
  end

  function automatic logic [TAG_W-1:0] fwd_tag(
    input logic [AR_W-1:0]                ar,
    input int unsigned                    slot,
    input DP_MT_WRITE [DP_NUM-1:0]        wr,
    input logic [MT_ENTRY-1:0][TAG_W-1:0] tags
  );
    fwd_tag = tags[ar];
    for (int unsigned j = 0; j < DP_NUM; j++)
      if (j < slot && wr[j].write_en && wr[j].rd == ar)
        fwd_tag = wr[j].tag;
  endfunction

  function automatic logic fwd_ready(
    input logic [AR_W-1:0]         ar,
    input int unsigned             slot,
    input DP_MT_WRITE [DP_NUM-1:0] wr,
    input logic [MT_ENTRY-1:0]     rdy
  );
    fwd_ready = rdy[ar];
    for (int unsigned j = 0; j < DP_NUM; j++)
      if (j < slot && wr[j].write_en && wr[j].rd == ar)
        fwd_ready = 1'b0;
  endfunction

  always_comb begin
    for (int unsigned i = 0; i < DP_NUM; i++) begin
      mt.mt_dp_o[i] = '0;
      if (mt.dp_mt_read_i[i].read_en) begin
        mt.mt_dp_o[i].tag1       = fwd_tag(mt.dp_mt_read_i[i].rs1, i, mt.dp_mt_write_i, tag_q);
        mt.mt_dp_o[i].tag1_ready = fwd_ready(mt.dp_mt_read_i[i].rs1, i, mt.dp_mt_write_i, eff_ready);
        mt.mt_dp_o[i].tag2       = fwd_tag(mt.dp_mt_read_i[i].rs2, i, mt.dp_mt_write_i, tag_q);
        mt.mt_dp_o[i].tag2_ready = fwd_ready(mt.dp_mt_read_i[i].rs2, i, mt.dp_mt_write_i, eff_ready);
      end
      if (mt.dp_mt_write_i[i].write_en)
        mt.mt_dp_o[i].tag_old = fwd_tag(mt.dp_mt_write_i[i].rd, i, mt.dp_mt_write_i, tag_q);
    end
  end

  // CDB updates are issued first so later dispatch writes to the same entry win.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      for (int unsigned k = 0; k < MT_ENTRY; k++) begin
        tag_q[k]   <= TAG_W'(k);
        ready_q[k] <= 1'b1;
      end
    end else if (mt.rollback_i) begin
      for (int unsigned k = 0; k < MT_ENTRY; k++) begin
        tag_q[k]   <= mt.amt_i[k].amt_tag;
        ready_q[k] <= 1'b1;
      end
    end else begin
      for (int unsigned k = 0; k < MT_ENTRY; k++)
        for (int unsigned c = 0; c < CDB_NUM; c++)
          if (mt.cdb_i[c].valid && mt.cdb_i[c].tag == tag_q[k])
            ready_q[k] <= 1'b1;
      for (int unsigned i = 0; i < DP_NUM; i++)
        if (mt.dp_mt_write_i[i].write_en) begin
          tag_q[mt.dp_mt_write_i[i].rd]   <= mt.dp_mt_write_i[i].tag;
          ready_q[mt.dp_mt_write_i[i].rd] <= 1'b0;
        end
    end
  end

  always_comb begin
    unused_ok = 1'b0;
    for (int unsigned c = 0; c < CDB_NUM; c++)
      unused_ok = unused_ok ^ (^{mt.cdb_i[c].rob_idx, mt.cdb_i[c].thread_idx, mt.cdb_i[c].br_result});
    for (int unsigned i = 0; i < DP_NUM; i++)
      unused_ok = unused_ok ^ (^{mt.dp_mt_read_i[i].thread_idx, mt.dp_mt_write_i[i].thread_idx});
  end
endmodule

// File: tb/tb_map_table.sv
// Directed bench for map_table: reset identity, forwarding, CDB wakeup, rollback and async reset.
// Honours MT_CDB_BYPASS_EN for the same-cycle ready expectation.
module tb_map_table;
  import map_table_pkg::*;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   vectors = 0;
  int   errors = 0;

`ifdef MT_CDB_BYPASS_EN
  localparam int BYP = 1;
`else
  localparam int BYP = 0;
`endif

  always #5 clk = ~clk;

  map_table_if #(.DP_NUM(2), .MT_ENTRY(32), .CDB_NUM(2)) bus ();

  map_table #(.DP_NUM(2), .MT_ENTRY(32), .CDB_NUM(2), .PRF_ENTRY(64)) dut (
    .clk_i (clk),
    .rst_i (rst_n),
    .mt    (bus.slave)
  );

  task automatic chk(input string name, input int obs, input int exp);
    vectors++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", name, obs, exp);
    end
  endtask

  task automatic chk_slot(input string name, input int s, input int t1, input int r1,
                          input int t2, input int r2, input int told);
    chk({name, ".tag1"},       int'(bus.mt_dp_o[s].tag1),       t1);
    chk({name, ".tag1_ready"}, int'(bus.mt_dp_o[s].tag1_ready), r1);
    chk({name, ".tag2"},       int'(bus.mt_dp_o[s].tag2),       t2);
    chk({name, ".tag2_ready"}, int'(bus.mt_dp_o[s].tag2_ready), r2);
    chk({name, ".tag_old"},    int'(bus.mt_dp_o[s].tag_old),    told);
  endtask

  task automatic idle();
    bus.rollback_i    = 1'b0;
    bus.cdb_i         = '0;
    bus.dp_mt_read_i  = '0;
    bus.dp_mt_write_i = '0;
  endtask

  task automatic set_rd(input int s, input int en, input int a, input int b);
    bus.dp_mt_read_i[s].read_en = 1'(en);
    bus.dp_mt_read_i[s].rs1     = 5'(a);
    bus.dp_mt_read_i[s].rs2     = 5'(b);
  endtask

  task automatic set_wr(input int s, input int en, input int rd, input int tag);
    bus.dp_mt_write_i[s].write_en = 1'(en);
    bus.dp_mt_write_i[s].rd       = 5'(rd);
    bus.dp_mt_write_i[s].tag      = 6'(tag);
  endtask

  task automatic set_cdb(input int l, input int v, input int tag);
    bus.cdb_i[l].valid = 1'(v);
    bus.cdb_i[l].tag   = 6'(tag);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    idle();
    rst_n = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;
    #2;
  endtask

  initial begin
    idle();
    for (int k = 0; k < 32; k++) bus.amt_i[k].amt_tag = 6'(k + 32);

    // Reset identity
    do_reset();
    set_rd(0, 1, 0, 5); set_rd(1, 1, 7, 8); #2;
    chk_slot("rst_s0", 0, 0, 1, 5, 1, 0);
    chk_slot("rst_s1", 1, 7, 1, 8, 1, 0);

    // tag_old from the pre-write mapping
    set_wr(0, 1, 0, 32); set_wr(1, 1, 7, 37); #2;
    chk_slot("told_s0", 0, 0, 1, 5, 1, 0);
    chk_slot("told_s1", 1, 7, 1, 8, 1, 7);

    // Same register as source and destination
    do_reset();
    set_rd(0, 1, 7, 7); set_wr(0, 1, 7, 32);
    set_rd(1, 1, 8, 8); set_wr(1, 1, 8, 37); #2;
    chk_slot("same_s0", 0, 7, 1, 7, 1, 7);
    chk_slot("same_s1", 1, 8, 1, 8, 1, 8);
    tick();
    idle(); set_rd(0, 1, 7, 8); set_rd(1, 1, 5, 6); #2;
    chk_slot("after_s0", 0, 32, 0, 37, 0, 0);
    chk_slot("after_s1", 1, 5, 1, 6, 1, 0);

    // CDB wakeup; slot1 disabled must read zeros
    set_rd(1, 0, 7, 8); set_cdb(0, 1, 32); set_cdb(1, 1, 37); #2;
    chk_slot("cdb_same_s0", 0, 32, BYP, 37, BYP, 0);
    chk_slot("rd_dis_s1", 1, 0, 0, 0, 0, 0);
    tick();
    idle(); set_rd(0, 1, 7, 8); #2;
    chk_slot("cdb_next_s0", 0, 32, 1, 37, 1, 0);

    // Intra-group forwarding
    do_reset();
    set_wr(0, 1, 3, 40);
    set_rd(1, 1, 3, 4); set_wr(1, 1, 3, 41); #2;
    chk_slot("fwd_s1", 1, 40, 0, 4, 1, 40);
    chk("fwd_s0.tag_old", int'(bus.mt_dp_o[0].tag_old), 3);
    tick();
    idle(); set_rd(0, 1, 3, 4); #2;
    chk_slot("fwd_next_s0", 0, 41, 0, 4, 1, 0);

    // Dispatch write overrides a same-cycle CDB match on the same entry
    set_wr(0, 1, 3, 41); set_cdb(0, 1, 41); #2;
    tick();
    idle(); set_rd(0, 1, 3, 4); #2;
    chk_slot("wr_over_cdb", 0, 41, 0, 4, 1, 0);

    // Rollback wins over dispatch write and CDB
    set_wr(0, 1, 5, 50); set_cdb(0, 1, 41); bus.rollback_i = 1'b1; #2;
    tick();
    idle(); set_rd(0, 1, 3, 5); set_rd(1, 1, 0, 31); #2;
    chk_slot("rb_s0", 0, 35, 1, 37, 1, 0);
    chk_slot("rb_s1", 1, 32, 1, 63, 1, 0);

    // Asynchronous reset mid-cycle discards a pending write
    set_wr(0, 1, 3, 50); #1;
    rst_n = 1'b0; #1;
    chk_slot("async_rst_s0", 0, 3, 1, 5, 1, 3);
    tick();
    set_wr(0, 0, 0, 0); rst_n = 1'b1; #2;
    tick();
    chk_slot("post_rst_s0", 0, 3, 1, 5, 1, 0);
    chk_slot("post_rst_s1", 1, 0, 1, 31, 1, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end
endmodule
